// File: rtl/wave_capture_trig_if.sv
// Sample-in / RAM-write bundle between a sample source, the capture block and the display RAM.
// Master drives samples and trigger settings; slave (the capture block) drives the write port.
interface wave_capture_trig_if #(
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_LOG2 = 8
);
    logic                  new_sample_ready;
    logic [SAMPLE_W-1:0]   new_sample_in;
    logic [SAMPLE_W-1:0]   trig_level;
    logic                  trig_falling;
    logic                  wave_display_idle;
    logic [DEPTH_LOG2:0]   write_address;
    logic                  write_enable;
    logic [OUT_W-1:0]      write_sample;
    logic                  read_index;
    logic                  auto_triggered;

    modport master (
        output new_sample_ready, new_sample_in, trig_level, trig_falling, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index, auto_triggered
    );

    modport slave (
        input  new_sample_ready, new_sample_in, trig_level, trig_falling, wave_display_idle,
        output write_address, write_enable, write_sample, read_index, auto_triggered
    );
endinterface

// File: rtl/wave_capture_trig.sv
// Edge-triggered waveform capture into a double-buffered RAM; write port registered (1 cycle after strobe).
// Optional auto-trigger after AUTO_TIMEOUT armed strobes is enabled by macro WAVE_CAPTURE_AUTO_TRIG_EN.
module wave_capture_trig #(
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int DEPTH_LOG2   = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    wave_capture_trig_if.slave  bus
);
    typedef enum logic [2:0] {
        ARMED  = 3'b100,
        ACTIVE = 3'b010,
        WAIT   = 3'b001
    } state_e;

    if (OUT_W > SAMPLE_W || AUTO_TIMEOUT < 1) begin : g_bad_params
        $error("wave_capture_trig: OUT_W must not exceed SAMPLE_W and AUTO_TIMEOUT must be >= 1");
    end

    state_e                        state_q, state_d;
    logic                          read_index_q, read_index_d;
    logic signed [SAMPLE_W-1:0]    prev_q, prev_d;
    logic                          prev_valid_q, prev_valid_d;
    logic [DEPTH_LOG2-1:0]         count_q, count_d;
    logic                          we_q, we_d;
    logic [DEPTH_LOG2:0]           waddr_q, waddr_d;
    logic [OUT_W-1:0]              wsample_q, wsample_d;

    logic signed [SAMPLE_W-1:0]    sample_s, level_s;
    logic [OUT_W-1:0]              sample_top;
    logic                          strobe, rise_hit, fall_hit, edge_trig, auto_trig, enter_armed;
    logic                          wr;
    logic [DEPTH_LOG2-1:0]         wr_idx;

    assign strobe      = bus.new_sample_ready;
    assign sample_s    = bus.new_sample_in;
    assign level_s     = bus.trig_level;
    assign sample_top  = bus.new_sample_in[SAMPLE_W-1 -: OUT_W];
    assign rise_hit    = (prev_q <  level_s) && (sample_s >= level_s);
    assign fall_hit    = (prev_q >= level_s) && (sample_s <  level_s);
    assign edge_trig   = prev_valid_q && (bus.trig_falling ? fall_hit : rise_hit);
    assign enter_armed = (state_q == WAIT) && bus.wave_display_idle;

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    localparam int ACW = $clog2(AUTO_TIMEOUT + 1);
    logic [ACW-1:0] acnt_q, acnt_d;
    logic           auto_q, auto_d;

    always_comb begin
        acnt_d    = acnt_q;
        auto_d    = auto_q;
        auto_trig = 1'b0;
        if (state_q == ARMED && strobe) begin
            acnt_d    = acnt_q + ACW'(1);
            auto_trig = !edge_trig && (acnt_q == ACW'(AUTO_TIMEOUT - 1));
            if (edge_trig)      auto_d = 1'b0;
            else if (auto_trig) auto_d = 1'b1;
        end
        if (enter_armed) begin
            acnt_d = '0;
            auto_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acnt_q <= '0;
            auto_q <= 1'b0;
        end else begin
            acnt_q <= acnt_d;
            auto_q <= auto_d;
        end
    end

    assign bus.auto_triggered = auto_q;
`else
    assign auto_trig          = 1'b0;
    assign bus.auto_triggered = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        read_index_d = read_index_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        count_d      = count_q;
        wr           = 1'b0;
        wr_idx       = '0;
        case (state_q)
            ARMED: begin
                if (strobe) begin
                    prev_d       = sample_s;
                    prev_valid_d = 1'b1;
                    if (edge_trig || auto_trig) begin
                        wr      = 1'b1;
                        count_d = DEPTH_LOG2'(1);
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (strobe) begin
                    prev_d  = sample_s;
                    wr      = 1'b1;
                    wr_idx  = count_q;
                    count_d = count_q + DEPTH_LOG2'(1);
                    if (&count_q) state_d = WAIT;
                end
            end
            WAIT: begin
                // Any strobe here is dropped, including one coincident with the release.
                if (bus.wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    prev_valid_d = 1'b0;
                    count_d      = '0;
                    state_d      = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase

        we_d      = wr;
        waddr_d   = waddr_q;
        wsample_d = wsample_q;
        if (wr) begin
            waddr_d              = {~read_index_q, wr_idx};
            wsample_d            = sample_top;
            wsample_d[OUT_W-1]   = ~sample_top[OUT_W-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARMED;
            read_index_q <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            count_q      <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wsample_q    <= '0;
        end else begin
            state_q      <= state_d;
            read_index_q <= read_index_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            count_q      <= count_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wsample_q    <= wsample_d;
        end
    end

    assign bus.write_enable  = we_q;
    assign bus.write_address = waddr_q;
    assign bus.write_sample  = wsample_q;
    assign bus.read_index    = read_index_q;
endmodule

// File: tb/tb_wave_capture_trig.sv
// Directed bench for wave_capture_trig; auto-trigger expectations follow WAVE_CAPTURE_AUTO_TRIG_EN.
module tb_wave_capture_trig;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    wave_capture_trig_if #(.SAMPLE_W(16), .OUT_W(8), .DEPTH_LOG2(8)) bus ();

    wave_capture_trig #(
        .SAMPLE_W(16), .OUT_W(8), .DEPTH_LOG2(8), .AUTO_TIMEOUT(4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a one-cycle strobe; returns 1ns after the accepting edge, when the write is visible.
    task automatic strobe(input logic [15:0] s);
        bus.new_sample_in    = s;
        bus.new_sample_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.new_sample_ready = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        tests++; if (dut.state_q !== 3'b100) begin fails++; $display("FAIL reset_state got %b want 100", dut.state_q); end
        tests++; if (bus.read_index !== 1'b0) begin fails++; $display("FAIL reset_read_index got %b want 0", bus.read_index); end
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", bus.write_enable); end
        tests++; if (bus.write_address !== 9'h000) begin fails++; $display("FAIL reset_waddr got %h want 000", bus.write_address); end
        tests++; if (bus.write_sample !== 8'h00) begin fails++; $display("FAIL reset_wsample got %h want 00", bus.write_sample); end
        tests++; if (bus.auto_triggered !== 1'b0) begin fails++; $display("FAIL reset_auto got %b want 0", bus.auto_triggered); end
    endtask

    task automatic test_rising();
        bus.trig_level   = 16'h0000;
        bus.trig_falling = 1'b0;
        strobe(16'hE000);
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL rise_first_we got %b want 0", bus.write_enable); end
        strobe(16'hC000);
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL rise_below_we got %b want 0", bus.write_enable); end
        strobe(16'h4000);
        tests++; if (bus.write_enable !== 1'b1) begin fails++; $display("FAIL rise_trig_we got %b want 1", bus.write_enable); end
        tests++; if (bus.write_address !== 9'h100) begin fails++; $display("FAIL rise_trig_waddr got %h want 100", bus.write_address); end
        tests++; if (bus.write_sample !== 8'hC0) begin fails++; $display("FAIL rise_trig_wsample got %h want c0", bus.write_sample); end
        tests++; if (dut.state_q !== 3'b010) begin fails++; $display("FAIL rise_active got %b want 010", dut.state_q); end
        for (int i = 1; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            strobe({b, 8'h00});
            tests++;
            if (bus.write_enable !== 1'b1 || bus.write_address !== (9'h100 + 9'(i)) || bus.write_sample !== (b ^ 8'h80)) begin
                fails++;
                $display("FAIL rise_fill[%0d] got we=%b addr=%h smp=%h want we=1 addr=%h smp=%h",
                         i, bus.write_enable, bus.write_address, bus.write_sample, 9'h100 + 9'(i), b ^ 8'h80);
            end
        end
        tests++; if (dut.state_q !== 3'b001) begin fails++; $display("FAIL rise_wait got %b want 001", dut.state_q); end
        idle_cycle();
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL rise_we_pulse got %b want 0", bus.write_enable); end
        tests++; if (bus.write_address !== 9'h1FF) begin fails++; $display("FAIL rise_addr_hold got %h want 1ff", bus.write_address); end
    endtask

    task automatic test_wait_release();
        strobe(16'h1234);
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL wait_strobe_we got %b want 0", bus.write_enable); end
        bus.wave_display_idle = 1'b1;
        strobe(16'h5678);
        bus.wave_display_idle = 1'b0;
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL release_strobe_we got %b want 0", bus.write_enable); end
        tests++; if (bus.read_index !== 1'b1) begin fails++; $display("FAIL release_read_index got %b want 1", bus.read_index); end
        tests++; if (dut.state_q !== 3'b100) begin fails++; $display("FAIL release_armed got %b want 100", dut.state_q); end
        bus.wave_display_idle = 1'b1;
        idle_cycle();
        bus.wave_display_idle = 1'b0;
        tests++; if (bus.read_index !== 1'b1) begin fails++; $display("FAIL armed_idle_ignored got %b want 1", bus.read_index); end
        strobe(16'hFFFF);
        strobe(16'h0100);
        tests++; if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h000 || bus.write_sample !== 8'h81) begin
            fails++; $display("FAIL cap2_trig got we=%b addr=%h smp=%h want 1 000 81", bus.write_enable, bus.write_address, bus.write_sample);
        end
        for (int i = 1; i < 256; i++) begin
            bus.wave_display_idle = (i <= 10);
            strobe(16'h7700);
            tests++;
            if (bus.write_enable !== 1'b1 || bus.write_address !== 9'(i)) begin
                fails++; $display("FAIL cap2_fill[%0d] got we=%b addr=%h want 1 %h", i, bus.write_enable, bus.write_address, 9'(i));
            end
        end
        bus.wave_display_idle = 1'b0;
        tests++; if (bus.read_index !== 1'b1) begin fails++; $display("FAIL active_idle_ignored got %b want 1", bus.read_index); end
        tests++; if (dut.state_q !== 3'b001) begin fails++; $display("FAIL cap2_wait got %b want 001", dut.state_q); end
        bus.wave_display_idle = 1'b1;
        idle_cycle();
        bus.wave_display_idle = 1'b0;
        tests++; if (bus.read_index !== 1'b0 || dut.state_q !== 3'b100) begin
            fails++; $display("FAIL release2 got ri=%b st=%b want 0 100", bus.read_index, dut.state_q);
        end
    endtask

    task automatic test_falling();
        bus.trig_falling = 1'b1;
        bus.trig_level   = 16'h1000;
        strobe(16'h2000);
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL fall_first_we got %b want 0", bus.write_enable); end
        strobe(16'h0800);
        tests++; if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h88) begin
            fails++; $display("FAIL fall_trig got we=%b addr=%h smp=%h want 1 100 88", bus.write_enable, bus.write_address, bus.write_sample);
        end
        for (int i = 1; i < 10; i++) strobe(16'h0000);
        tests++; if (bus.write_address !== 9'h109) begin fails++; $display("FAIL fall_tenth_addr got %h want 109", bus.write_address); end
    endtask

    task automatic test_reset_mid_active();
        pulse_reset();
        tests++; if (dut.state_q !== 3'b100 || bus.read_index !== 1'b0 || bus.write_enable !== 1'b0 || bus.write_address !== 9'h000) begin
            fails++; $display("FAIL midreset got st=%b ri=%b we=%b addr=%h want 100 0 0 000",
                              dut.state_q, bus.read_index, bus.write_enable, bus.write_address);
        end
        bus.trig_falling = 1'b0;
        bus.trig_level   = 16'h0000;
        strobe(16'h4000);
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL midreset_first_we got %b want 0", bus.write_enable); end
        strobe(16'hC000);
        tests++; if (bus.write_enable !== 1'b0) begin fails++; $display("FAIL midreset_fall_ignored got %b want 0", bus.write_enable); end
        strobe(16'h1000);
        tests++; if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h90) begin
            fails++; $display("FAIL midreset_retrig got we=%b addr=%h smp=%h want 1 100 90", bus.write_enable, bus.write_address, bus.write_sample);
        end
    endtask

    task automatic test_auto_trigger();
        bit saw_write;
        pulse_reset();
        bus.trig_falling = 1'b0;
        bus.trig_level   = 16'h4000;
        saw_write = 1'b0;
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
        for (int i = 0; i < 4095; i++) begin
            strobe(16'h0000);
            if (bus.write_enable === 1'b1) saw_write = 1'b1;
        end
        tests++; if (saw_write !== 1'b0) begin fails++; $display("FAIL auto_early_write got %b want 0", saw_write); end
        strobe(16'h0000);
        tests++; if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h80) begin
            fails++; $display("FAIL auto_trig got we=%b addr=%h smp=%h want 1 100 80", bus.write_enable, bus.write_address, bus.write_sample);
        end
        tests++; if (bus.auto_triggered !== 1'b1) begin fails++; $display("FAIL auto_flag got %b want 1", bus.auto_triggered); end
`else
        for (int i = 0; i < 5000; i++) begin
            strobe(16'h0000);
            if (bus.write_enable === 1'b1) saw_write = 1'b1;
        end
        tests++; if (saw_write !== 1'b0) begin fails++; $display("FAIL noauto_write got %b want 0", saw_write); end
        tests++; if (bus.auto_triggered !== 1'b0) begin fails++; $display("FAIL noauto_flag got %b want 0", bus.auto_triggered); end
        tests++; if (dut.state_q !== 3'b100) begin fails++; $display("FAIL noauto_state got %b want 100", dut.state_q); end
`endif
    endtask

    initial begin
        tests                 = 0;
        fails                 = 0;
        reset                 = 1'b1;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.trig_level        = '0;
        bus.trig_falling      = 1'b0;
        bus.wave_display_idle = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rising();
        test_wait_release();
        test_falling();
        test_reset_mid_active();
        test_auto_trigger();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wave_capture_trig.md
WAVE_CAPTURE_TRIG -- requirements
Module: wave_capture_trig

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, input sample width (signed two's complement).
REQ-002 SHALL have parameter OUT_W, default 8, stored sample width (OUT_W <= SAMPLE_W).
REQ-003 SHALL have parameter DEPTH_LOG2, default 8, log2 of samples per capture buffer.
REQ-004 SHALL have parameter AUTO_TIMEOUT, default 4096, auto-trigger sample count (used only under REQ-027).
REQ-005 SHALL have one clock and an asynchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  async active-high reset.
REQ-006 SHALL have: new_sample_ready  input  1  one-cycle strobe, new_sample_in valid.
REQ-007 SHALL have: new_sample_in  input  SAMPLE_W  signed sample.
REQ-008 SHALL have: trig_level  input  SAMPLE_W  signed trigger threshold.
REQ-009 SHALL have: trig_falling  input  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-010 SHALL have: wave_display_idle  input  1  display finished reading its buffer.
REQ-011 SHALL have: write_address  output  DEPTH_LOG2+1  {buffer bit, index} into double-buffered RAM.
REQ-012 SHALL have: write_enable  output  1; write_sample  output  OUT_W; read_index  output  1  buffer the display reads; auto_triggered  output  1.

Function
REQ-013 SHALL implement one-hot states ARMED=3'b100, ACTIVE=3'b010, WAIT=3'b001.
REQ-014 SHALL, in ARMED, on each strobe, compare previous accepted sample p with new sample n (signed): rising trigger when p < trig_level and n >= trig_level; falling trigger when p >= trig_level and n < trig_level.
REQ-015 SHALL hold a prev_valid flag, cleared on reset and on entering ARMED; a strobe with prev_valid=0 only loads p and cannot trigger.
REQ-016 SHALL write the triggering sample as index 0, set count=1, enter ACTIVE.
REQ-017 SHALL, in ACTIVE, write each strobed sample at index count, increment count; after writing index 2^DEPTH_LOG2-1 enter WAIT.
REQ-018 SHALL write to buffer ~read_index: write_address = {~read_index, index}.
REQ-019 SHALL convert write_sample = new_sample_in[SAMPLE_W-1 -: OUT_W] with MSB inverted (offset binary).
REQ-020 SHALL register write_enable/write_address/write_sample: asserted exactly one cycle after the accepting strobe, for one cycle; write_address/write_sample hold last value otherwise.
REQ-021 SHALL ignore strobes in WAIT (no write, p not updated).
REQ-022 SHALL, in WAIT with wave_display_idle=1, toggle read_index and enter ARMED next cycle; a simultaneous strobe is discarded.
REQ-023 SHALL ignore wave_display_idle in ARMED and ACTIVE.
REQ-024 SHALL sample trig_level/trig_falling only on strobe cycles; changes take effect on next strobe.

Reset
REQ-025 SHALL on reset (any time, incl. mid-ACTIVE) force state=ARMED, read_index=0, write_enable=0, write_address=0, write_sample=0, count=0, prev_valid=0, auto_triggered=0; partial buffer abandoned.

Configuration
REQ-026 SHALL key auto-trigger on macro WAVE_CAPTURE_AUTO_TRIG_EN.
REQ-027 SHALL, with macro defined, count strobes in ARMED (cleared on entering ARMED); the AUTO_TIMEOUT-th strobe without edge trigger is treated as trigger (REQ-016) and sets auto_triggered=1 until next ARMED entry; edge trigger clears it to 0.
REQ-028 SHALL, without macro, omit the counter, tie auto_triggered to 0, trigger on edges only.

Verification
REQ-029 Reset pulse -> state 3'b100, read_index 0, write_enable 0, write_address 0.
REQ-030 Rising, level 0: strobes 0xE000, 0xC000, 0x4000 -> one cycle later write_enable=1, write_address=9'h100, write_sample=8'hC0; 255 more strobes write 9'h101..9'h1FF, state 3'b001.
REQ-031 In WAIT, strobe plus wave_display_idle pulse -> no write, read_index=1, ARMED; next capture writes 9'h000..9'h0FF.
REQ-032 trig_falling=1, level 0x1000: strobes 0x2000, 0x0800 -> write at index 0 with write_sample=8'h88.
REQ-033 Reset after 10 ACTIVE writes -> ARMED, read_index 0; first post-reset strobe 0x4000 (level 0) produces no write.
REQ-034 Level 0x4000, constant 0x0000 strobes: macro defined -> 4096th strobe written at index 0, auto_triggered=1; undefined -> no write after 5000 strobes.
